counter_cmd_ctrl: RTL and testbench
===================================

Name: counter_cmd_ctrl

Overview:
- Command front end sitting directly upstream of the 32-bit up/down counter.
- Takes three raw asynchronous push-button/switch inputs (count-up, count-down, pause) and produces the counter's `up` (direction) and `ctrl` (hold) controls.
- Each input is synchronised and debounced, then reduced to a press pulse. A small FSM turns the pulses into clean, glitch-free direction/hold commands.
- Every direction reversal passes through a one-cycle hold, so the counter never sees a direction flip while it is counting.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive identical synchronised samples required before a debounced level changes (range 2..2^20; 4 for simulation, board builds override).
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1, width of each debounce counter (derived; not to be overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- btn_up_raw  input  1  raw count-up request, async, active-high.
- btn_down_raw  input  1  raw count-down request, async, active-high.
- btn_pause_raw  input  1  raw pause/resume toggle, async, active-high.
- up  output  1  direction to counter: 1 = up, 0 = down; registered.
- ctrl  output  1  hold to counter: 1 = hold value, 0 = count; registered.
- state_o  output  3  current FSM state encoding, for debug/LEDs.

Behaviour:

Reset:
- Reset is synchronous and active-low, applied while rst_n = 0 at a clk edge.
- Reset values: up = 1, ctrl = 1, state = STOPPED (3'd0).
- All synchroniser flops, debounced levels, debounce counters, press registers and the saved-direction register clear to 0.
- Reset mid-operation (any state, any debounce count) aborts everything and returns to these values on the same edge. The first press is accepted only after a fresh full debounce.

Input path (per input, identical, independent):
- 2-flop synchroniser, giving sync2.
- Debounce counter:
  - If sync2 == db, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then db <= sync2 and cnt <= 0.
  - Else cnt <= cnt+1.
- Any bounce (sync2 returning to db) restarts the count.
- press <= db & ~db_d, where db_d is db delayed by one register. press is a 1-cycle registered pulse on the debounced rising edge only; release generates nothing.

Latency:
- A raw level that changes before edge E and stays stable is reflected as follows:
  - sync2 at edge E+1.
  - db at edge E+1+DEBOUNCE_CYCLES.
  - press at edge E+2+DEBOUNCE_CYCLES.
  - up/ctrl at edge E+3+DEBOUNCE_CYCLES.
- For DEBOUNCE_CYCLES = 4 this is 7 edges.
- A pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.

FSM states (state_o):

| State | Encoding | up | ctrl |
|---|---|---|---|
| STOPPED | 0 | 1 | 1 |
| RUN_UP | 1 | 1 | 0 |
| RUN_DOWN | 2 | 0 | 0 |
| PAUSED | 3 | saved_dir | 1 |
| TURN | 4 | new dir | 1 |

- Outputs are decoded from the next state and registered, so they change on the same edge as the state.

FSM transitions (evaluated on press pulses):
- pause has the highest priority.
  - RUN_UP/RUN_DOWN -> PAUSED, saving the direction.
  - PAUSED -> RUN_UP or RUN_DOWN according to saved_dir.
  - STOPPED or TURN: pause is ignored.
- up and down pressed in the same cycle, with no pause press: ignored, no state change.
- up press:
  - STOPPED or PAUSED -> RUN_UP.
  - RUN_DOWN -> TURN with target up.
  - RUN_UP or TURN: no change.
- down press:
  - STOPPED or PAUSED -> RUN_DOWN.
  - RUN_UP -> TURN with target down.
  - RUN_DOWN or TURN: no change.
- TURN lasts exactly 1 cycle, then goes unconditionally to RUN_UP or RUN_DOWN per the target. Presses arriving while in TURN are dropped.
- Illegal encodings (5-7) -> STOPPED on the next edge, with up = 1, ctrl = 1.

Invariants:
- `up` may change only on a cycle where ctrl = 1 in both the previous and the new cycle, or on entry from STOPPED/PAUSED (where the previous ctrl = 1).
- There is never a cycle with ctrl = 0 in which up differs from its value in the preceding ctrl = 0 cycle of the same run.

Test Plan:
1. Reset check: rst_n = 0 for 2 edges, with btn_up_raw = 1 held throughout. Required: up = 1, ctrl = 1, state_o = 0 during reset. After rst_n = 1, RUN_UP (up = 1, ctrl = 0) is reached exactly 7 edges later, i.e. a fresh debounce is required.
2. Bounce rejection: btn_down_raw toggles 1,0,1,0 every 2 cycles, then holds 1. Required: no press during the toggling. RUN_DOWN (up = 0, ctrl = 0, state_o = 2) is reached 7 edges after the final rising edge.
3. Reversal: from RUN_UP, a clean btn_down_raw press. Required: state_o = 4 with up = 0, ctrl = 1 for exactly 1 cycle, then state_o = 2 with up = 0, ctrl = 0.
4. Pause/resume: in RUN_DOWN, press pause -> state_o = 3, ctrl = 1, up = 0. Press pause again -> state_o = 2, ctrl = 0, up = 0.
5. Simultaneous presses:
   - btn_up_raw and btn_down_raw rise in the same cycle from STOPPED -> state stays 0.
   - All three rise together from RUN_UP -> PAUSED, with saved_dir = 1.
6. Reset mid-debounce and in TURN:
   - Assert rst_n = 0 while in TURN -> STOPPED next edge, up = 1, ctrl = 1.
   - Assert rst_n = 0 with a debounce counter at 2 -> no press is emitted afterwards until a full 4-sample debounce completes.

Source files
------------

// File: rtl/counter_cmd_ctrl.sv
// Command front end for the up/down counter: synchronises and debounces three
// raw buttons, then turns their press pulses into registered up/ctrl commands.
module counter_cmd_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_pause_raw,
  output logic       up,
  output logic       ctrl,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    STOPPED  = 3'd0,
    RUN_UP   = 3'd1,
    RUN_DOWN = 3'd2,
    PAUSED   = 3'd3,
    TURN     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 = up, bit 1 = down, bit 2 = pause.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q, db_q, db_dly_q, press_q;
  logic [CNT_W-1:0] cnt_q [3];

  assign raw = {btn_pause_raw, btn_down_raw, btn_up_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      press_q  <= db_q & ~db_dly_q;
      // Any sample matching the current level restarts the count.
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e state_q, state_d;
  logic   saved_dir_q, saved_dir_d;
  logic   turn_dir_q, turn_dir_d;
  logic   up_q, up_d, ctrl_q, ctrl_d;
  logic   p_up, p_dn, p_ps;

  assign p_up = press_q[0];
  assign p_dn = press_q[1];
  assign p_ps = press_q[2];

  always_comb begin
    state_d     = state_q;
    saved_dir_d = saved_dir_q;
    turn_dir_d  = turn_dir_q;
    case (state_q)
      STOPPED: begin
        if (p_up && !p_dn)      state_d = RUN_UP;
        else if (p_dn && !p_up) state_d = RUN_DOWN;
      end
      RUN_UP: begin
        if (p_ps) begin
          state_d     = PAUSED;
          saved_dir_d = 1'b1;
        end else if (p_dn && !p_up) begin
          state_d    = TURN;
          turn_dir_d = 1'b0;
        end
      end
      RUN_DOWN: begin
        if (p_ps) begin
          state_d     = PAUSED;
          saved_dir_d = 1'b0;
        end else if (p_up && !p_dn) begin
          state_d    = TURN;
          turn_dir_d = 1'b1;
        end
      end
      PAUSED: begin
        if (p_ps)               state_d = saved_dir_q ? RUN_UP : RUN_DOWN;
        else if (p_up && !p_dn) state_d = RUN_UP;
        else if (p_dn && !p_up) state_d = RUN_DOWN;
      end
      TURN:    state_d = turn_dir_q ? RUN_UP : RUN_DOWN;
      default: state_d = STOPPED;
    endcase
  end

  // Outputs decoded from the next state so they move on the same edge as it.
  always_comb begin
    up_d   = 1'b1;
    ctrl_d = 1'b1;
    case (state_d)
      RUN_UP: begin
        up_d   = 1'b1;
        ctrl_d = 1'b0;
      end
      RUN_DOWN: begin
        up_d   = 1'b0;
        ctrl_d = 1'b0;
      end
      PAUSED:  up_d = saved_dir_d;
      TURN:    up_d = turn_dir_d;
      default: begin
        up_d   = 1'b1;
        ctrl_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= STOPPED;
      saved_dir_q <= 1'b0;
      turn_dir_q  <= 1'b0;
      up_q        <= 1'b1;
      ctrl_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      saved_dir_q <= saved_dir_d;
      turn_dir_q  <= turn_dir_d;
      up_q        <= up_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign up      = up_q;
  assign ctrl    = ctrl_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl with DEBOUNCE_CYCLES = 4: a raw level set
// before edge E is expected to show on state/up/ctrl after edge E+7.
module tb_counter_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_raw = 1'b0, btn_down_raw = 1'b0, btn_pause_raw = 1'b0;
  logic       up, ctrl;
  logic [2:0] state_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  counter_cmd_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_up_raw    (btn_up_raw),
    .btn_down_raw  (btn_down_raw),
    .btn_pause_raw (btn_pause_raw),
    .up            (up),
    .ctrl          (ctrl),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic u, input logic c);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_up"},    32'(up),      32'(u));
    chk({tag, "_ctrl"},  32'(ctrl),    32'(c));
  endtask

  // Inputs were just changed before edge E: the old state must still hold after
  // E+6 and the new outputs must be present after E+7.
  task automatic arrive(input string tag, input logic [2:0] old_st,
                        input logic [2:0] st, input logic u, input logic c);
    tick(7);
    chk({tag, "_early"}, 32'(state_o), 32'(old_st));
    tick(1);
    chk_out(tag, st, u, c);
  endtask

  task automatic release_all();
    btn_up_raw    = 1'b0;
    btn_down_raw  = 1'b0;
    btn_pause_raw = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with up held: a full debounce is needed after release
    btn_up_raw = 1'b1;
    tick(2);
    chk_out("reset", 3'd0, 1'b1, 1'b1);
    rst_n = 1'b1;
    arrive("rst_up", 3'd0, 3'd1, 1'b1, 1'b0);
    release_all();

    // Bounce rejection on down, then a clean hold
    do_reset();
    chk_out("stop2", 3'd0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      btn_down_raw = 1'b1;
      tick(2);
      chk("bounce_hi", 32'(state_o), 32'd0);
      btn_down_raw = 1'b0;
      tick(2);
      chk("bounce_lo", 32'(state_o), 32'd0);
    end
    btn_down_raw = 1'b1;
    arrive("bounce_down", 3'd0, 3'd2, 1'b0, 1'b0);
    release_all();

    // Reversals go through one TURN cycle
    btn_up_raw = 1'b1;
    arrive("turn_to_up", 3'd2, 3'd4, 1'b1, 1'b1);
    tick(1);
    chk_out("run_up3", 3'd1, 1'b1, 1'b0);
    release_all();
    btn_down_raw = 1'b1;
    arrive("turn_to_down", 3'd1, 3'd4, 1'b0, 1'b1);
    tick(1);
    chk_out("run_down3", 3'd2, 1'b0, 1'b0);
    release_all();

    // Pause / resume in RUN_DOWN
    btn_pause_raw = 1'b1;
    arrive("pause", 3'd2, 3'd3, 1'b0, 1'b1);
    release_all();
    btn_pause_raw = 1'b1;
    arrive("resume_dn", 3'd3, 3'd2, 1'b0, 1'b0);
    release_all();

    // Simultaneous up+down from STOPPED is ignored
    do_reset();
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    tick(8);
    chk_out("both", 3'd0, 1'b1, 1'b1);
    tick(4);
    chk("both_late", 32'(state_o), 32'd0);
    release_all();

    // All three from RUN_UP: pause wins and saves direction up
    btn_up_raw = 1'b1;
    arrive("up5", 3'd0, 3'd1, 1'b1, 1'b0);
    release_all();
    btn_up_raw    = 1'b1;
    btn_down_raw  = 1'b1;
    btn_pause_raw = 1'b1;
    arrive("all3", 3'd1, 3'd3, 1'b1, 1'b1);
    release_all();
    btn_pause_raw = 1'b1;
    arrive("resume_up", 3'd3, 3'd1, 1'b1, 1'b0);
    release_all();

    // Reset while in TURN
    btn_down_raw = 1'b1;
    arrive("turn6", 3'd1, 3'd4, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick(1);
    chk_out("rst_turn", 3'd0, 1'b1, 1'b1);
    rst_n = 1'b1;
    btn_down_raw = 1'b0;
    tick(8);
    chk("idle_after_rst", 32'(state_o), 32'd0);

    // Reset with the up debounce counter at 2: needs a fresh full debounce
    btn_up_raw = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk_out("rst_mid_db", 3'd0, 1'b1, 1'b1);
    rst_n = 1'b1;
    arrive("fresh_db", 3'd0, 3'd1, 1'b1, 1'b0);
    release_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
